// File: rtl/program_counter_fetch.sv
// program_counter_fetch: architectural PC plus a single-outstanding instruction fetch with redirect/drop.
// Optional PC_MISALIGN_TRAP_EN: misaligned redirects are ignored and pulse Misalign_Trap.
module program_counter_fetch #(
    parameter int unsigned       DWIDTH       = 32,
    parameter logic [DWIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Redirect_Valid,
    input  logic [DWIDTH-1:0] Redirect_Target,
    output logic              Imem_Req_Valid,
    input  logic              Imem_Req_Ready,
    output logic [DWIDTH-1:0] Imem_Req_Addr,
    input  logic              Imem_Rsp_Valid,
    input  logic [31:0]       Imem_Rsp_Data,
    output logic              Fetch_Valid,
    input  logic              Fetch_Ready,
    output logic [DWIDTH-1:0] Fetch_Pc,
    output logic [DWIDTH-1:0] Fetch_Pc_Plus4,
    output logic [31:0]       Fetch_Instr,
    output logic              Misalign_Trap
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_e;
    state_e            state_q, state_d;
    logic [DWIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d, fpc_q, fpc_d, fpc4_q, fpc4_d;
    logic [DWIDTH-1:0] target, req_pc_plus4;
    logic [31:0]       instr_q, instr_d;
    logic              drop_q, drop_d, redir;

    assign target       = Redirect_Target & ~DWIDTH'(3);
    assign req_pc_plus4 = req_pc_q + DWIDTH'(4);

`ifdef PC_MISALIGN_TRAP_EN
    logic trap_q;
    assign redir         = Redirect_Valid && Redirect_Target[1:0] == 2'b00;
    assign Misalign_Trap = trap_q;
    always_ff @(posedge Clk) begin
        trap_q <= Rst ? 1'b0 : Redirect_Valid && Redirect_Target[1:0] != 2'b00;
    end
`else
    assign redir         = Redirect_Valid;
    assign Misalign_Trap = 1'b0;
`endif

    // Rst gates the request so nothing is issued while memory is also in reset
    assign Imem_Req_Valid = state_q == REQ && !Rst;
    assign Imem_Req_Addr  = pc_q;
    assign Fetch_Valid    = state_q == HOLD;
    assign Fetch_Pc       = fpc_q;
    assign Fetch_Pc_Plus4 = fpc4_q;
    assign Fetch_Instr    = instr_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        fpc_d    = fpc_q;
        fpc4_d   = fpc4_q;
        instr_d  = instr_q;
        case (state_q)
            REQ: begin
                if (Imem_Req_Ready) begin
                    state_d  = WAIT;
                    req_pc_d = pc_q;
                    drop_d   = redir;
                end
            end
            WAIT: begin
                if (Imem_Rsp_Valid && (drop_q || redir)) begin
                    state_d = REQ;
                    drop_d  = 1'b0;
                end else if (Imem_Rsp_Valid) begin
                    state_d = HOLD;
                    fpc_d   = req_pc_q;
                    fpc4_d  = req_pc_plus4;
                    instr_d = Imem_Rsp_Data;
                    pc_d    = req_pc_plus4;
                end else if (redir) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: state_d = (redir || Fetch_Ready) ? REQ : HOLD;
            default: state_d = REQ;
        endcase
        // redirect wins over any sequential PC update
        if (redir) pc_d = target;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= REQ;
            pc_q     <= RESET_VECTOR;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
            fpc_q    <= '0;
            fpc4_q   <= '0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            fpc_q    <= fpc_d;
            fpc4_q   <= fpc4_d;
            instr_q  <= instr_d;
        end
    end
endmodule

// File: tb/tb_program_counter_fetch.sv
// tb_program_counter_fetch: randomized and directed bench for program_counter_fetch.
// Reference: next presented PC is sequential unless an accepted redirect replaces it.
module tb_program_counter_fetch;
    logic        Clk = 1'b0, Rst = 1'b1, Redirect_Valid = 1'b0;
    logic [31:0] Redirect_Target = '0;
    logic        Imem_Req_Ready = 1'b0, Imem_Rsp_Valid = 1'b0, Fetch_Ready = 1'b0;
    logic [31:0] Imem_Rsp_Data = '0;
    logic        req_valid, fetch_valid, trap, w_req_valid, w_fetch_valid, w_trap;
    logic [31:0] req_addr, fetch_pc, fetch_pc4, fetch_instr;
    logic [31:0] w_req_addr, w_fetch_pc, w_fetch_pc4, w_fetch_instr;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    program_counter_fetch dut (
        .Clk(Clk), .Rst(Rst), .Redirect_Valid(Redirect_Valid), .Redirect_Target(Redirect_Target),
        .Imem_Req_Valid(req_valid), .Imem_Req_Ready(Imem_Req_Ready), .Imem_Req_Addr(req_addr),
        .Imem_Rsp_Valid(Imem_Rsp_Valid), .Imem_Rsp_Data(Imem_Rsp_Data),
        .Fetch_Valid(fetch_valid), .Fetch_Ready(Fetch_Ready), .Fetch_Pc(fetch_pc),
        .Fetch_Pc_Plus4(fetch_pc4), .Fetch_Instr(fetch_instr), .Misalign_Trap(trap)
    );

    program_counter_fetch #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
        .Clk(Clk), .Rst(Rst), .Redirect_Valid(Redirect_Valid), .Redirect_Target(Redirect_Target),
        .Imem_Req_Valid(w_req_valid), .Imem_Req_Ready(Imem_Req_Ready), .Imem_Req_Addr(w_req_addr),
        .Imem_Rsp_Valid(Imem_Rsp_Valid), .Imem_Rsp_Data(Imem_Rsp_Data),
        .Fetch_Valid(w_fetch_valid), .Fetch_Ready(Fetch_Ready), .Fetch_Pc(w_fetch_pc),
        .Fetch_Pc_Plus4(w_fetch_pc4), .Fetch_Instr(w_fetch_instr), .Misalign_Trap(w_trap)
    );

    always #5 Clk = ~Clk;

    int          checks = 0, failures = 0;
    int          mem_lat = 1, cnt = 0;
    bit          pending = 0, spur_en = 0;
    logic [31:0] exp_pc = '0, mem_addr = '0;
    logic        exp_trap = 1'b0;
    logic [31:0] req_log[$], xfer_log[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEADBEEF;
    endfunction

    // one clock: drive inputs at negedge, model memory, score handshakes due at the next posedge
    task cycle(input bit rv, input logic [31:0] tgt, input bit rr, input bit fr);
        @(negedge Clk);
        Redirect_Valid = rv; Redirect_Target = tgt; Imem_Req_Ready = rr; Fetch_Ready = fr;
        Imem_Rsp_Valid = 1'b0; Imem_Rsp_Data = $urandom;
        if (pending) begin
            cnt--;
            if (cnt == 0) begin
                Imem_Rsp_Valid = 1'b1; Imem_Rsp_Data = instr_of(mem_addr); pending = 0;
            end
        end else if (spur_en && $urandom_range(0, 3) == 0) Imem_Rsp_Valid = 1'b1;
        #1;
        checks++;
        if (trap !== exp_trap) begin failures++; $display("FAIL misalign_trap: got %b want %b", trap, exp_trap); end
        if (req_valid && rr) begin
            checks++;
            if (req_addr !== exp_pc) begin failures++; $display("FAIL req_addr: got %h want %h", req_addr, exp_pc); end
            req_log.push_back(req_addr);
            pending = 1; mem_addr = req_addr; cnt = mem_lat > 0 ? mem_lat : int'($urandom_range(1, 3));
        end
        if (fetch_valid && fr) begin
            checks += 3;
            if (fetch_pc !== exp_pc) begin failures++; $display("FAIL fetch_pc: got %h want %h", fetch_pc, exp_pc); end
            if (fetch_pc4 !== exp_pc + 32'd4) begin failures++; $display("FAIL fetch_pc4: got %h want %h", fetch_pc4, exp_pc + 32'd4); end
            if (fetch_instr !== instr_of(exp_pc)) begin failures++; $display("FAIL fetch_instr: got %h want %h", fetch_instr, instr_of(exp_pc)); end
            xfer_log.push_back(fetch_pc);
            exp_pc = exp_pc + 32'd4;
        end
        if (rv && (!TRAP_EN || tgt[1:0] == 2'b00)) exp_pc = tgt & ~32'h3;
        exp_trap = TRAP_EN && rv && tgt[1:0] != 2'b00;
        @(posedge Clk);
    endtask

    task assert_rst();
        @(negedge Clk);
        Rst = 1'b1; Redirect_Valid = 1'b0; Imem_Req_Ready = 1'b0; Imem_Rsp_Valid = 1'b0; Fetch_Ready = 1'b0;
        pending = 0;
        repeat (2) @(negedge Clk);
    endtask

    task release_rst();
        Rst = 1'b0; exp_pc = '0; exp_trap = 1'b0;
        req_log.delete(); xfer_log.delete();
        #1;
    endtask

    task reset_dut();
        assert_rst();
        release_rst();
    endtask

    task test_sequential();
        reset_dut();
        mem_lat = 1;
        repeat (9) cycle(1'b0, '0, 1'b1, 1'b1);
        checks += 3;
        if (req_log.size() != 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8) begin
            failures++; $display("FAIL seq_req_addrs: got %0d reqs want 0x0,0x4,0x8", req_log.size());
        end
        if (xfer_log.size() != 3) begin failures++; $display("FAIL seq_throughput: got %0d want 3", xfer_log.size()); end
        if (xfer_log.size() < 2 || xfer_log[0] !== 32'h0 || xfer_log[1] !== 32'h4) begin
            failures++; $display("FAIL seq_fetch_pcs: got %0d fetches want pcs 0x0,0x4", xfer_log.size());
        end
    endtask

    task test_reset();
        assert_rst();
        #1;
        checks += 6;
        if (req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
        if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rst_fetch_valid: got %b want 0", fetch_valid); end
        if (fetch_pc !== 32'h0) begin failures++; $display("FAIL rst_fetch_pc: got %h want 0", fetch_pc); end
        if (fetch_pc4 !== 32'h0) begin failures++; $display("FAIL rst_fetch_pc4: got %h want 0", fetch_pc4); end
        if (fetch_instr !== 32'h0) begin failures++; $display("FAIL rst_fetch_instr: got %h want 0", fetch_instr); end
        if (trap !== 1'b0) begin failures++; $display("FAIL rst_trap: got %b want 0", trap); end
        release_rst();
        checks += 2;
        if (req_valid !== 1'b1) begin failures++; $display("FAIL rst_first_req: got %b want 1", req_valid); end
        if (req_addr !== 32'h0) begin failures++; $display("FAIL rst_first_addr: got %h want 0", req_addr); end
    endtask

    task test_hold_stall();
        reset_dut();
        mem_lat = 1;
        for (int i = 0; i < 10 && !fetch_valid; i++) begin cycle(1'b0, '0, 1'b1, 1'b0); #1; end
        checks++;
        if (!fetch_valid) begin failures++; $display("FAIL stall_reach_hold: got %b want 1", fetch_valid); end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0); #1;
            checks += 3;
            if (fetch_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b want 1", fetch_valid); end
            if (fetch_pc !== 32'h0 || fetch_instr !== instr_of(32'h0)) begin
                failures++; $display("FAIL stall_stable: got %h/%h want 0/%h", fetch_pc, fetch_instr, instr_of(32'h0));
            end
            if (req_valid !== 1'b0) begin failures++; $display("FAIL stall_no_req: got %b want 0", req_valid); end
        end
        cycle(1'b0, '0, 1'b1, 1'b1); #1;
        checks += 2;
        if (req_valid !== 1'b1 || req_addr !== 32'h4) begin
            failures++; $display("FAIL stall_next_req: got %b/%h want 1/00000004", req_valid, req_addr);
        end
        if (fetch_valid !== 1'b0) begin failures++; $display("FAIL stall_release: got %b want 0", fetch_valid); end
    endtask

    task test_redirect_wait();
        reset_dut();
        mem_lat = 4;
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, 32'h100, 1'b1, 1'b1);
        for (int i = 0; i < 30 && xfer_log.size() < 1; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        checks += 2;
        if (xfer_log.size() < 1 || xfer_log[0] !== 32'h100) begin
            failures++; $display("FAIL rw_first_pc: got %0d fetches want first pc 00000100", xfer_log.size());
        end
        if (req_log.size() < 2 || req_log[1] !== 32'h100) begin
            failures++; $display("FAIL rw_next_req: got %0d reqs want second addr 00000100", req_log.size());
        end
        mem_lat = 1;
    endtask

    task test_redirect_req();
        reset_dut();
        mem_lat = 1;
        repeat (6) cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, 32'h200, 1'b1, 1'b1);
        for (int i = 0; i < 30 && xfer_log.size() < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        checks += 2;
        if (req_log.size() < 4 || req_log[2] !== 32'h8 || req_log[3] !== 32'h200) begin
            failures++; $display("FAIL rr_reqs: got %0d reqs want third 00000008 fourth 00000200", req_log.size());
        end
        if (xfer_log.size() < 3 || xfer_log[2] !== 32'h200) begin
            failures++; $display("FAIL rr_third_pc: got %0d fetches want third pc 00000200", xfer_log.size());
        end
    endtask

    task test_misalign();
        logic [31:0] want;
        reset_dut();
        mem_lat = 1;
        want = TRAP_EN ? 32'h0 : 32'h100;
        cycle(1'b1, 32'h102, 1'b0, 1'b1); #1;
        checks += 2;
        if (trap !== TRAP_EN) begin failures++; $display("FAIL mis_trap_pulse: got %b want %b", trap, TRAP_EN); end
        if (req_addr !== want) begin failures++; $display("FAIL mis_addr: got %h want %h", req_addr, want); end
        cycle(1'b0, '0, 1'b0, 1'b1); #1;
        checks++;
        if (trap !== 1'b0) begin failures++; $display("FAIL mis_trap_end: got %b want 0", trap); end
        for (int i = 0; i < 20 && xfer_log.size() < 1; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (xfer_log.size() < 1 || xfer_log[0] !== want) begin
            failures++; $display("FAIL mis_first_pc: got %0d fetches want first pc %h", xfer_log.size(), want);
        end
    endtask

    task test_wrap();
        reset_dut();
        mem_lat = 1;
        checks++;
        if (w_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first_addr: got %h want fffffffc", w_req_addr); end
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b1);
        #1;
        checks += 2;
        if (w_fetch_valid !== 1'b1 || w_fetch_pc !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_fetch_pc: got %b/%h want 1/fffffffc", w_fetch_valid, w_fetch_pc);
        end
        if (w_fetch_pc4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4: got %h want 0", w_fetch_pc4); end
        cycle(1'b0, '0, 1'b1, 1'b1); #1;
        checks++;
        if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin
            failures++; $display("FAIL wrap_second_addr: got %b/%h want 1/0", w_req_valid, w_req_addr);
        end
    endtask

    task test_random();
        logic [31:0] tgt;
        reset_dut();
        mem_lat = 0;
        spur_en = 1;
        for (int i = 0; i < 800; i++) begin
            tgt = $urandom;
            if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
            cycle($urandom_range(0, 9) == 0, tgt, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
        end
        spur_en = 0;
        mem_lat = 1;
        checks++;
        if (xfer_log.size() < 30) begin failures++; $display("FAIL rand_progress: got %0d fetches want >=30", xfer_log.size()); end
    endtask

    initial begin
        reset_dut();
        test_sequential();
        test_reset();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_req();
        test_misalign();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
